// File: rtl/bitcnt_pkg.sv
// Shared types and helpers for the pipelined bit-counting unit.
package bitcnt_pkg;

  typedef enum logic [2:0] {
    MODE_CLZ = 3'd0,
    MODE_CLO = 3'd1,
    MODE_CTZ = 3'd2,
    MODE_CTO = 3'd3,
    MODE_POP = 3'd4
  } mode_t;

  // Modes that scan from the MSB end
  function automatic logic is_leading(input mode_t m);
    return (m == MODE_CLZ) || (m == MODE_CLO);
  endfunction

  // Modes that scan from the LSB end
  function automatic logic is_trailing(input mode_t m);
    return (m == MODE_CTZ) || (m == MODE_CTO);
  endfunction

  // Result width able to hold 0..width inclusive
  function automatic int unsigned count_w(input int unsigned width);
    return 32'($clog2(width)) + 32'd1;
  endfunction

endpackage

// File: rtl/bit_count_pipe_if.sv
// Operand/result handshake bundle for bit_count_pipe.
interface bit_count_pipe_if
  import bitcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) ();

  localparam int unsigned CNT_W = count_w(WIDTH);

  logic             in_valid;
  logic             in_ready;
  mode_t            in_mode;
  logic [WIDTH-1:0] in_value;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_mode, in_value, in_tag, out_ready,
    input  in_ready, out_valid, out_count, out_tag
  );

  modport slave (
    input  in_valid, in_mode, in_value, in_tag, out_ready,
    output in_ready, out_valid, out_count, out_tag
  );

endinterface

// File: rtl/bit_count_chunk.sv
// Combinational per-chunk counter: run length from either end or popcount.
module bit_count_chunk
  import bitcnt_pkg::*;
#(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0]       bits,
  input  mode_t                  mode,
  output logic [$clog2(CHUNK):0] count,
  output logic                   all_match
);

  localparam int unsigned CC_W = $clog2(CHUNK) + 1;

  logic tgt;
  logic run;

  // Count matching bits according to mode; unsupported codes give 0
  always_comb begin
    count = '0;
    run   = 1'b1;
    tgt   = (mode == MODE_CLO) || (mode == MODE_CTO);
    if (is_leading(mode)) begin
      for (int i = CHUNK - 1; i >= 0; i--) begin
        if (run && (bits[i] == tgt)) count = count + CC_W'(1);
        else                         run   = 1'b0;
      end
    end else if (is_trailing(mode)) begin
      for (int i = 0; i < CHUNK; i++) begin
        if (run && (bits[i] == tgt)) count = count + CC_W'(1);
        else                         run   = 1'b0;
      end
    end else if (mode == MODE_POP) begin
      for (int i = 0; i < CHUNK; i++) begin
        count = count + CC_W'(bits[i]);
      end
    end
  end

  assign all_match = (count == CC_W'(CHUNK));

endmodule

// File: rtl/bit_count_pipe.sv
// Two-stage pipelined CLZ/CLO/CTZ/CTO/POP unit with valid/ready and tag pass-through.
module bit_count_pipe
  import bitcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8,
  parameter int unsigned TAG_W = 5
) (
  input logic             clk,
  input logic             rst,
  input logic             flush,
  bit_count_pipe_if.slave bus
);

  localparam int unsigned CNT_W = count_w(WIDTH);
  localparam int unsigned NCH   = WIDTH / CHUNK;
  localparam int unsigned CC_W  = $clog2(CHUNK) + 1;

  logic [NCH-1:0][CC_W-1:0] chunk_cnt;
  logic [NCH-1:0]           chunk_full;

  logic                     s1_valid_q, s1_valid_d;
  mode_t                    s1_mode_q,  s1_mode_d;
  logic [TAG_W-1:0]         s1_tag_q,   s1_tag_d;
  logic [NCH-1:0][CC_W-1:0] s1_cnt_q,   s1_cnt_d;
  logic [NCH-1:0]           s1_full_q,  s1_full_d;

  logic                     out_valid_q, out_valid_d;
  logic [CNT_W-1:0]         out_count_q, out_count_d;
  logic [TAG_W-1:0]         out_tag_q,   out_tag_d;

  logic                     s2_advance;
  logic                     accept;
  logic [CNT_W-1:0]         combined;
  logic                     scan_run;

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    bit_count_chunk #(.CHUNK(CHUNK)) u_chunk (
      .bits      (bus.in_value[g*CHUNK +: CHUNK]),
      .mode      (bus.in_mode),
      .count     (chunk_cnt[g]),
      .all_match (chunk_full[g])
    );
  end

  // Stage 1 may load whenever stage 2 will move or stage 1 is empty
  assign s2_advance   = !out_valid_q || bus.out_ready;
  assign bus.in_ready = !s1_valid_q || s2_advance;
  assign accept       = bus.in_valid && bus.in_ready;

  // Stage 1 next state: capture chunk results on accept, drop on flush
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_mode_d  = s1_mode_q;
    s1_tag_d   = s1_tag_q;
    s1_cnt_d   = s1_cnt_q;
    s1_full_d  = s1_full_q;
    if (bus.in_ready) s1_valid_d = accept;
    if (accept) begin
      s1_mode_d = bus.in_mode;
      s1_tag_d  = bus.in_tag;
      s1_cnt_d  = chunk_cnt;
      s1_full_d = chunk_full;
    end
    if (flush) s1_valid_d = 1'b0;
  end

  // Combine chunk results: accumulate full chunks until the first partial one
  always_comb begin
    combined = '0;
    scan_run = 1'b1;
    if (is_leading(s1_mode_q)) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (scan_run) begin
          combined = combined + CNT_W'(s1_cnt_q[i]);
          scan_run = s1_full_q[i];
        end
      end
    end else if (is_trailing(s1_mode_q)) begin
      for (int i = 0; i < NCH; i++) begin
        if (scan_run) begin
          combined = combined + CNT_W'(s1_cnt_q[i]);
          scan_run = s1_full_q[i];
        end
      end
    end else if (s1_mode_q == MODE_POP) begin
      for (int i = 0; i < NCH; i++) begin
        combined = combined + CNT_W'(s1_cnt_q[i]);
      end
    end
  end

  // Stage 2 next state: hold under back-pressure, drop valid on flush
  always_comb begin
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_tag_d   = out_tag_q;
    if (s2_advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_count_d = combined;
        out_tag_d   = s1_tag_q;
      end
    end
    if (flush) out_valid_d = 1'b0;
  end

  // Pipeline registers with synchronous reset clearing data as well
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mode_q   <= MODE_CLZ;
      s1_tag_q    <= '0;
      s1_cnt_q    <= '0;
      s1_full_q   <= '0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mode_q   <= s1_mode_d;
      s1_tag_q    <= s1_tag_d;
      s1_cnt_q    <= s1_cnt_d;
      s1_full_q   <= s1_full_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_count = out_count_q;
  assign bus.out_tag   = out_tag_q;

endmodule

// File: tb/tb_bit_count_pipe.sv
// Scoreboard bench for bit_count_pipe: 32/8 and 64/4 instances side by side.
module tb_bit_count_pipe;
  import bitcnt_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, flush_a, flush_b;

  bit_count_pipe_if #(.WIDTH(32), .TAG_W(5)) bus_a ();
  bit_count_pipe_if #(.WIDTH(64), .TAG_W(5)) bus_b ();

  bit_count_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(5)) dut_a (
    .clk(clk), .rst(rst_a), .flush(flush_a), .bus(bus_a)
  );
  bit_count_pipe #(.WIDTH(64), .CHUNK(4), .TAG_W(5)) dut_b (
    .clk(clk), .rst(rst_b), .flush(flush_b), .bus(bus_b)
  );

  typedef struct {
    int         cnt;
    logic [4:0] tag;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Bitwise reference count, independent of chunking
  function automatic int model(input int w, input logic [2:0] m, input logic [63:0] v);
    int n   = 0;
    bit run = 1'b1;
    case (m)
      3'd0, 3'd1: for (int i = w - 1; i >= 0; i--) begin
        if (run && (v[i] == m[0])) n++;
        else run = 1'b0;
      end
      3'd2, 3'd3: for (int i = 0; i < w; i++) begin
        if (run && (v[i] == m[0])) n++;
        else run = 1'b0;
      end
      3'd4: for (int i = 0; i < w; i++) n += int'(v[i]);
      default: n = 0;
    endcase
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_a(input logic [2:0] m, input logic [31:0] v, input logic [4:0] tag, input int exp);
    bit acc = 1'b0;
    bus_a.in_valid = 1'b1;
    bus_a.in_mode  = mode_t'(m);
    bus_a.in_value = v;
    bus_a.in_tag   = tag;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bus_a.in_ready) begin
        acc = 1'b1;
        if (!flush_a && !rst_a) q_a.push_back('{cnt: exp, tag: tag});
      end
      @(posedge clk);
      #1;
    end
    bus_a.in_valid = 1'b0;
    check_eq("a_accept", 64'(acc), 64'd1);
  endtask

  task automatic send_b(input logic [2:0] m, input logic [63:0] v, input logic [4:0] tag, input int exp);
    bit acc = 1'b0;
    bus_b.in_valid = 1'b1;
    bus_b.in_mode  = mode_t'(m);
    bus_b.in_value = v;
    bus_b.in_tag   = tag;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      if (bus_b.in_ready) begin
        acc = 1'b1;
        if (!flush_b && !rst_b) q_b.push_back('{cnt: exp, tag: tag});
      end
      @(posedge clk);
      #1;
    end
    bus_b.in_valid = 1'b0;
    check_eq("b_accept", 64'(acc), 64'd1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 50 && q_a.size() != 0; i++) tick(1);
    check_eq("a_drain", 64'(q_a.size()), 64'd0);
  endtask

  task automatic drain_b();
    for (int i = 0; i < 50 && q_b.size() != 0; i++) tick(1);
    check_eq("b_drain", 64'(q_b.size()), 64'd0);
  endtask

  // Result monitors: compare deliveries, then forget anything a flush/reset kills
  always @(negedge clk) begin
    exp_t e;
    if (bus_a.out_valid && bus_a.out_ready) begin
      if (q_a.size() == 0) check_eq("a_spurious", 64'(q_a.size()), 64'd1);
      else begin
        e = q_a.pop_front();
        check_eq("a_count", 64'(bus_a.out_count), 64'(e.cnt));
        check_eq("a_tag", 64'(bus_a.out_tag), 64'(e.tag));
      end
    end
    if (flush_a || rst_a) q_a.delete();
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus_b.out_valid && bus_b.out_ready) begin
      if (q_b.size() == 0) check_eq("b_spurious", 64'(q_b.size()), 64'd1);
      else begin
        e = q_b.pop_front();
        check_eq("b_count", 64'(bus_b.out_count), 64'(e.cnt));
        check_eq("b_tag", 64'(bus_b.out_tag), 64'(e.tag));
      end
    end
    if (flush_b || rst_b) q_b.delete();
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; flush_a = 1'b0; flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_mode = MODE_CLZ; bus_a.in_value = '0;
    bus_a.in_tag = '0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_mode = MODE_CLZ; bus_b.in_value = '0;
    bus_b.in_tag = '0; bus_b.out_ready = 1'b1;
    tick(3);

    // Reset state
    @(negedge clk);
    check_eq("rst_a_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("rst_a_count", 64'(bus_a.out_count), 64'd0);
    check_eq("rst_a_tag", 64'(bus_a.out_tag), 64'd0);
    check_eq("rst_b_valid", 64'(bus_b.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check_eq("rst_a_in_ready", 64'(bus_a.in_ready), 64'd1);
    check_eq("rst_b_in_ready", 64'(bus_b.in_ready), 64'd1);
    @(posedge clk); #1;

    // Leading zeros with latency check on the first op
    send_a(3'd0, 32'h00F0_0000, 5'd1, 8);
    @(negedge clk);
    check_eq("lat_cycle1_valid", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", 64'(bus_a.out_valid), 64'd1);
    @(posedge clk); #1;
    send_a(3'd0, 32'h0000_0000, 5'd2, 32);
    send_a(3'd0, 32'h8000_0000, 5'd3, 0);

    // Leading ones, trailing modes, popcount, unsupported code
    send_a(3'd1, 32'hFFFF_FF00, 5'd4, 24);
    send_a(3'd1, 32'hFFFF_FFFF, 5'd5, 32);
    send_a(3'd1, 32'h7FFF_FFFF, 5'd6, 0);
    send_a(3'd2, 32'h0000_0100, 5'd7, 8);
    send_a(3'd3, 32'h0000_00FF, 5'd8, 8);
    send_a(3'd4, 32'hF0F0_0001, 5'd9, 9);
    send_a(3'd6, 32'h1234_5678, 5'd10, 0);
    drain_a();

    // Random operands with long runs, back-to-back
    for (int i = 0; i < 24; i++) begin
      logic [2:0]  m;
      logic [31:0] v;
      int          k;
      m = 3'($urandom_range(0, 7));
      k = $urandom_range(0, 31);
      v = $urandom;
      case ($urandom_range(0, 3))
        1: v = v >> k;
        2: v = ~(v >> k);
        3: v = v << k;
        default: ;
      endcase
      send_a(m, v, 5'(i), model(32, m, {32'd0, v}));
    end
    drain_a();

    // Back-pressure: two accepts, then stall with held output
    bus_a.out_ready = 1'b0;
    send_a(3'd0, 32'h0000_FFFF, 5'd1, 16);
    send_a(3'd4, 32'h0000_000F, 5'd2, 4);
    @(negedge clk);
    check_eq("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
    check_eq("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_hold_count", 64'(bus_a.out_count), 64'd16);
      check_eq("bp_hold_tag", 64'(bus_a.out_tag), 64'd1);
      check_eq("bp_hold_in_ready", 64'(bus_a.in_ready), 64'd0);
    end
    @(posedge clk); #1;
    fork
      send_a(3'd2, 32'h0000_0010, 5'd3, 4);
      begin
        @(posedge clk); #1;
        bus_a.out_ready = 1'b1;
      end
    join
    @(negedge clk);
    check_eq("bp_seq2_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("bp_seq2_tag", 64'(bus_a.out_tag), 64'd2);
    @(negedge clk);
    check_eq("bp_seq3_valid", 64'(bus_a.out_valid), 64'd1);
    check_eq("bp_seq3_tag", 64'(bus_a.out_tag), 64'd3);
    @(posedge clk); #1;
    drain_a();

    // Flush with both stages occupied and the consumer stalled
    bus_a.out_ready = 1'b0;
    send_a(3'd0, 32'h0000_0001, 5'd11, 31);
    send_a(3'd0, 32'h0000_0003, 5'd12, 30);
    flush_a = 1'b1;
    @(posedge clk); #1;
    flush_a = 1'b0;
    @(negedge clk);
    check_eq("fl1_out_valid", 64'(bus_a.out_valid), 64'd0);
    check_eq("fl1_in_ready", 64'(bus_a.in_ready), 64'd1);
    @(posedge clk); #1;
    bus_a.out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_eq("fl1_idle_valid", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk); #1;

    // Flush with a result delivered and an input accepted in the same cycle
    send_a(3'd4, 32'hFFFF_FFFF, 5'd13, 32);
    send_a(3'd4, 32'h0000_0000, 5'd14, 0);
    flush_a = 1'b1;
    send_a(3'd1, 32'hF000_0000, 5'd15, 4);
    flush_a = 1'b0;
    @(negedge clk);
    check_eq("fl2_out_valid", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk); #1;
    send_a(3'd0, 32'h0000_0001, 5'd16, 31);
    drain_a();

    // 64-bit operands with 4-bit chunks
    send_b(3'd0, 64'h0000_0000_0000_0001, 5'd1, 63);
    send_b(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64);
    send_b(3'd2, 64'h0000_0000_0000_0000, 5'd3, 64);
    send_b(3'd1, 64'hFFFF_FFF0_0000_0000, 5'd4, 28);
    for (int i = 0; i < 12; i++) begin
      logic [2:0]  m;
      logic [63:0] v;
      int          k;
      m = 3'($urandom_range(0, 4));
      k = $urandom_range(0, 63);
      v = {$urandom, $urandom};
      if (i[0]) v = v >> k;
      else      v = ~(v << k);
      send_b(m, v, 5'(i + 8), model(64, m, v));
    end
    send_b(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 5'd30, 64);
    drain_b();

    // Reset with an op in flight
    send_b(3'd0, 64'h00FF_0000_0000_0000, 5'd5, 8);
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", 64'(bus_b.out_valid), 64'd0);
    check_eq("midrst_out_count", 64'(bus_b.out_count), 64'd0);
    check_eq("midrst_out_tag", 64'(bus_b.out_tag), 64'd0);
    check_eq("midrst_in_ready", 64'(bus_b.in_ready), 64'd1);
    @(posedge clk); #1;
    tick(2);
    send_b(3'd3, 64'h0000_0000_0000_000F, 5'd6, 4);
    drain_b();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
